// File: rtl/wr_ddr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wr_ddr_burst_ctrl
// Purpose  : Drains the 256-bit write-FIFO read port into fixed-length AXI4
//            write bursts at frame-linear addresses; pulses frame_done per frame.
// Revision : 1.0
// ============================================================================
module wr_ddr_burst_ctrl #(
  parameter int                    ADDR_WIDTH   = 28,
  parameter int                    DATA_WIDTH   = 256,
  parameter int                    LEVEL_WIDTH  = 9,
  parameter int                    BURST_LEN    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    FRAME_BURSTS = 7200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  output logic                      fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  input  logic                      fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0]    fifo_rd_water_level,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [7:0]                m_awlen,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic                      m_bvalid,
  input  logic [1:0]                m_bresp,
  output logic                      m_bready,
  output logic                      frame_done,
  output logic                      err_resp,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam int FCW = $clog2(FRAME_BURSTS + 1);
  localparam logic [BCW-1:0]         BL_C      = BCW'(BURST_LEN);
  localparam logic [BCW-1:0]         LAST_BEAT = BCW'(BURST_LEN - 1);
  localparam logic [FCW-1:0]         LAST_BRST = FCW'(FRAME_BURSTS - 1);
  localparam logic [LEVEL_WIDTH:0]   LEVEL_THR = (LEVEL_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [FCW-1:0]          burst_cnt_q, burst_cnt_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_q, err_d;
  logic [BCW-1:0]          req_q, req_d;
  logic [BCW-1:0]          beat_q, beat_d;
  logic                    inflight_q;

  logic [DATA_WIDTH-1:0]   sk_mem_q [2];
  logic                    sk_rd_ptr_q, sk_wr_ptr_q;
  logic [1:0]              sk_cnt_q;

  logic                    rd_en, push, pop, level_ok;
  logic [2:0]              occ;

  assign level_ok = {1'b0, fifo_rd_water_level} >= LEVEL_THR;
  assign push     = inflight_q;
  assign pop      = m_wvalid && m_wready;
  // Credit the beat leaving this cycle so a ready sink sees one beat per clock.
  assign occ      = {1'b0, sk_cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign rd_en    = (state_q == ST_W) && !fifo_rd_empty && (req_q < BL_C) && (occ < 3'd2);

  assign fifo_rd_en = rd_en;
  assign m_awaddr   = addr_q;
  assign m_awlen    = 8'(BURST_LEN - 1);
  assign m_awvalid  = (state_q == ST_AW);
  assign m_wstrb    = '1;
  assign m_wvalid   = (sk_cnt_q != 2'd0);
  assign m_wdata    = sk_mem_q[sk_rd_ptr_q];
  assign m_wlast    = m_wvalid && (beat_q == LAST_BEAT);
  assign m_bready   = (state_q == ST_B);
  assign frame_done = frame_done_q;
  assign err_resp   = err_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    burst_cnt_d  = burst_cnt_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    req_d        = req_q;
    beat_d       = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          addr_d      = BASE_ADDR;
          burst_cnt_d = '0;
        end
        if (level_ok && !pending_q) state_d = ST_AW;
      end
      ST_AW: begin
        if (frame_start) pending_d = 1'b1;
        if (m_awready) begin
          state_d = ST_W;
          req_d   = '0;
          beat_d  = '0;
        end
      end
      ST_W: begin
        if (frame_start) pending_d = 1'b1;
        if (rd_en) req_d = req_q + 1'b1;
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (m_wlast) state_d = ST_B;
        end
      end
      ST_B: begin
        if (m_bvalid) begin
          state_d = ST_IDLE;
          if (m_bresp != 2'b00) err_d = 1'b1;
          if (burst_cnt_q == LAST_BRST) begin
            addr_d       = BASE_ADDR;
            burst_cnt_d  = '0;
            frame_done_d = 1'b1;
          end else begin
            addr_d      = addr_q + ADDR_STEP;
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
          // A restart requested during this burst overrides the normal advance.
          if (pending_q || frame_start) begin
            addr_d      = BASE_ADDR;
            burst_cnt_d = '0;
            pending_d   = 1'b0;
          end
        end else if (frame_start) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= BASE_ADDR;
      burst_cnt_q  <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      req_q        <= '0;
      beat_q       <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      burst_cnt_q  <= burst_cnt_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      req_q        <= req_d;
      beat_q       <= beat_d;
      inflight_q   <= rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_mem_q[0] <= '0;
      sk_mem_q[1] <= '0;
      sk_rd_ptr_q <= 1'b0;
      sk_wr_ptr_q <= 1'b0;
      sk_cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        sk_mem_q[sk_wr_ptr_q] <= fifo_rd_data;
        sk_wr_ptr_q           <= ~sk_wr_ptr_q;
      end
      if (pop) sk_rd_ptr_q <= ~sk_rd_ptr_q;
      sk_cnt_q <= sk_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wr_ddr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_ddr_burst_ctrl
// Purpose  : Directed/randomized bench with queue-based FIFO and AXI slave models.
// Revision : 1.0
// ============================================================================
module tb_wr_ddr_burst_ctrl;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int LW = 9;
  localparam int BL = 16;
  localparam int FB = 3;
  localparam logic [AW-1:0] BASE = '0;
  localparam int BURST_BYTES = BL * DW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_start = 1'b0;
  logic            fifo_rd_en;
  logic [DW-1:0]   fifo_rd_data = '0;
  logic            fifo_rd_empty = 1'b1;
  logic [LW-1:0]   fifo_rd_water_level = '0;
  logic [AW-1:0]   m_awaddr;
  logic [7:0]      m_awlen;
  logic            m_awvalid;
  logic            m_awready = 1'b0;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_wlast, m_wvalid;
  logic            m_wready = 1'b0;
  logic            m_bvalid = 1'b0;
  logic [1:0]      m_bresp = 2'b00;
  logic            m_bready, frame_done, err_resp, busy;

  always #5 clk = ~clk;

  wr_ddr_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEVEL_WIDTH(LW),
    .BURST_LEN(BL), .BASE_ADDR(BASE), .FRAME_BURSTS(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .frame_done(frame_done), .err_resp(err_resp), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wd_q[$];
  logic          wl_q[$];
  int            wt_q[$];
  logic [AW-1:0] aw_q[$];

  int  cyc = 0, b_done = 0, b_owed = 0, rd_burst = 0, fd_cnt = 0, fd_at = -1;
  int  gbeat = 0, frame_idx = 0;
  bit  throttle = 1'b0;
  logic [1:0] bresp_next = 2'b00;
  bit  prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit  s_aw, s_w, s_b, s_rd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic push_words(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = rnd_word();
      fq.push_back(w);
      exp_q.push_back(w);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic wait_b(input int target, input int budget);
    int n;
    n = 0;
    while (b_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("bursts_done", b_done, target);
  endtask

  task automatic wait_wvalid(input int budget);
    int n;
    n = 0;
    while (!m_wvalid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wvalid_seen", m_wvalid, 1'b1);
  endtask

  // Frame-linear address model: burst k of a frame lives at BASE + k*burst bytes.
  task automatic check_aws(input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] exp_a, got;
      exp_a = BASE + AW'(frame_idx * BURST_BYTES);
      frame_idx = (frame_idx + 1) % FB;
      got = (aw_q.size() != 0) ? aw_q.pop_front() : 'x;
      chk("awaddr", got, exp_a);
    end
  endtask

  task automatic check_data();
    while (wd_q.size() > 0) begin
      logic [DW-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("wdata_order", wd_q.pop_front(), e);
      chk("wlast", wl_q.pop_front(), (gbeat % BL) == BL - 1);
      gbeat++;
    end
    chk("beats_outstanding", exp_q.size(), 0);
    wt_q.delete();
  endtask

  // FIFO + AXI slave model: sample at negedge, drive just after posedge.
  always begin
    @(negedge clk);
    cyc++;
    s_aw = m_awvalid && m_awready;
    s_w  = m_wvalid && m_wready;
    s_b  = m_bvalid && m_bready;
    s_rd = fifo_rd_en;
    if (rst_n) begin
      if (prev_stall) begin
        chk("w_hold_valid", m_wvalid, 1'b1);
        chk("w_hold_data", m_wdata, prev_data);
      end
      prev_stall = m_wvalid && !m_wready;
      prev_data  = m_wdata;
      if (s_aw) begin
        aw_q.push_back(m_awaddr);
        chk("awlen", m_awlen, BL - 1);
      end
      if (s_w) begin
        wd_q.push_back(m_wdata);
        wl_q.push_back(m_wlast);
        wt_q.push_back(cyc);
        if (m_wlast) b_owed++;
      end
      if (s_rd) rd_burst++;
      if (s_b) begin
        chk("rd_per_burst", rd_burst, BL);
        rd_burst = 0;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_at = b_done;
      end
    end
    @(posedge clk);
    #1;
    if (s_b) begin
      b_done++;
      b_owed--;
      bresp_next = 2'b00;
    end
    if (s_rd) begin
      chk("rd_not_empty", fq.size() != 0, 1'b1);
      if (fq.size() != 0) fifo_rd_data = fq.pop_front();
    end
    fifo_rd_empty       = (fq.size() == 0);
    fifo_rd_water_level = LW'(fq.size());
    m_bvalid  = (b_owed > 0);
    m_bresp   = m_bvalid ? bresp_next : 2'b00;
    m_wready  = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    m_awready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    int lat, aw_seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_awaddr", m_awaddr, BASE);
    chk("rst_awlen", m_awlen, BL - 1);
    chk("rst_wvalid", m_wvalid, 1'b0);
    chk("rst_wstrb", m_wstrb, {(DW/8){1'b1}});
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_busy_done_err", {busy, frame_done, err_resp, m_bready, m_wlast}, 5'b0);
    rst_n = 1'b1;

    // First burst, back-to-back data, error response.
    bresp_next = 2'b10;
    push_words(16, 0);
    wait_b(1, 300);
    check_aws(1);
    chk("b2b_span", (wt_q.size() >= 16) ? wt_q[15] - wt_q[0] : -1, 15);
    check_data();
    chk("err_resp_set", err_resp, 1'b1);
    chk("no_frame_done_yet", fd_cnt, 0);

    // Three more bursts with throttled ready and a trickling FIFO; wraps the frame.
    throttle = 1'b1;
    push_words(48, 3);
    wait_b(4, 3000);
    check_aws(3);
    check_data();
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_after_b3", fd_at, 3);
    chk("err_resp_sticky", err_resp, 1'b1);
    throttle = 1'b0;

    // Level one short of a burst must not start anything.
    push_words(15, 0);
    aw_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_awvalid) aw_seen++;
    end
    chk("no_aw_at_level15", aw_seen, 0);
    push_words(1, 0);
    lat = 0;
    while (!m_awvalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("aw_latency_level16", lat, 2);
    wait_b(5, 300);
    check_aws(1);
    check_data();

    // Restart while idle takes effect immediately.
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    frame_idx = 0;
    push_words(16, 0);
    wait_b(6, 300);
    check_aws(1);
    check_data();

    // Restart during W: burst completes, next burst goes back to base.
    push_words(16, 0);
    wait_wvalid(100);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_b(7, 300);
    check_aws(1);
    frame_idx = 0;
    push_words(16, 0);
    wait_b(8, 300);
    check_aws(1);
    check_data();
    chk("no_frame_done_on_restart", fd_cnt, 1);

    // Asynchronous reset mid-burst clears outputs without a clock edge.
    push_words(16, 0);
    wait_wvalid(100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wvalid", m_wvalid, 1'b0);
    chk("arst_ctrl", {m_awvalid, busy, err_resp, m_bready, fifo_rd_en, m_wlast}, 6'b0);
    chk("arst_wdata", m_wdata, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
